// File: rtl/rv_pkg.sv
// RV32I decode definitions shared by the instruction decoder and the decode stage.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    logic        jump;
    logic [2:0]  br_funct3;
    logic        illegal;
  } dec_ctrl_t;

  // instr[30] only means SUB for register-register ops; immediate adds have no SUB form.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic bit30,
                                              input logic is_op);
    case (funct3)
      3'b000:  return (is_op && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder: control fields plus a sign-extended immediate.
module instr_decoder
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output dec_ctrl_t       ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  imm_type_e   imm_type;
  logic        imm_en;
  logic [31:0] imm32;

  assign opcode = instr_i[6:0];

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.rs1       = instr_i[19:15];
    ctrl_o.rs2       = instr_i[24:20];
    ctrl_o.rd        = instr_i[11:7];
    ctrl_o.br_funct3 = instr_i[14:12];
    ctrl_o.alu_ctrl  = ALU_ADD;
    ctrl_o.result_src = RES_ALU;
    imm_type         = IMM_I;
    imm_en           = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        imm_en = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_MEM;
      end
      OPC_OP_IMM: begin
        imm_en = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_ctrl  = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b0);
      end
      OPC_AUIPC: begin
        imm_en = 1'b1;
        imm_type = IMM_U;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm_en = 1'b1;
        imm_type = IMM_S;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_ctrl  = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b1);
      end
      OPC_LUI: begin
        imm_en = 1'b1;
        imm_type = IMM_U;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_ctrl  = ALU_PASSB;
      end
      OPC_BRANCH: begin
        imm_en = 1'b1;
        imm_type = IMM_B;
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
      end
      OPC_JALR, OPC_JAL: begin
        imm_en = 1'b1;
        imm_type = (opcode == OPC_JAL) ? IMM_J : IMM_I;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.result_src = RES_PC4;
      end
      // Unknown opcodes leave every side-effect enable at zero.
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    if (imm_en) begin
      case (imm_type)
        IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
        IMM_U:   imm32 = {instr_i[31:12], 12'b0};
        IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
        default: imm32 = '0;
      endcase
    end
  end

  assign imm_o = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes on the input side and holds results in a 2-entry skid buffer.
module decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [3:0]        out_alu_ctrl,
  output logic              out_alu_src,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic [1:0]        out_result_src,
  output logic              out_branch,
  output logic              out_jump,
  output logic [2:0]        out_br_funct3,
  output logic              out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   imm;
    dec_ctrl_t         ctrl;
  } entry_t;

  state_e          state_q, state_d;
  entry_t          out_q, out_d, skid_q, skid_d, in_entry;
  dec_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            in_ready_q;
  logic            accept, retire;

  instr_decoder #(.XLEN(XLEN)) u_dec (
    .instr_i (in_instr),
    .ctrl_o  (dec_ctrl),
    .imm_o   (dec_imm)
  );

  assign in_entry = {in_pc, dec_imm, dec_ctrl};
  assign accept   = in_valid && in_ready_q;
  assign retire   = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          out_d   = in_entry;
        end
        ONE: begin
          if (accept && retire) begin
            out_d = in_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        TWO: if (retire) begin
          state_d = ONE;
          out_d   = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes from the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != EMPTY);
  assign out_pc         = out_q.pc;
  assign out_imm        = out_q.imm;
  assign out_rs1        = out_q.ctrl.rs1;
  assign out_rs2        = out_q.ctrl.rs2;
  assign out_rd         = out_q.ctrl.rd;
  assign out_alu_ctrl   = out_q.ctrl.alu_ctrl;
  assign out_alu_src    = out_q.ctrl.alu_src;
  assign out_reg_write  = out_q.ctrl.reg_write;
  assign out_mem_write  = out_q.ctrl.mem_write;
  assign out_result_src = out_q.ctrl.result_src;
  assign out_branch     = out_q.ctrl.branch;
  assign out_jump       = out_q.ctrl.jump;
  assign out_br_funct3  = out_q.ctrl.br_funct3;
  assign out_illegal    = out_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model plus directed literal checks.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_ctrl;
  logic        out_alu_src, out_reg_write, out_mem_write, out_branch, out_jump, out_illegal;
  logic [1:0]  out_result_src;
  logic [2:0]  out_br_funct3;

  decode_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_result_src(out_result_src), .out_branch(out_branch),
    .out_jump(out_jump), .out_br_funct3(out_br_funct3), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    int          alu;
    logic        aluSrc, regWrite, memWrite, branch, jump, illegal;
    int          resultSrc;
    logic [2:0]  funct3;
  } exp_t;

  word_t       modelQ[$];
  logic [31:0] retiredPcs[$];
  int          passCount = 0;
  int          checkCount = 0;
  logic        checkOn = 1'b0;
  logic        mAcc, mRet;
  exp_t        cmpExp;

  // ALU codes by funct3: ADD SLL SLT SLTU XOR SRL OR AND
  function automatic int aluFor(input logic [2:0] f3, input logic b30, input logic isOp);
    int tbl[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int a;
    a = tbl[f3];
    if (f3 == 3'd0 && isOp && b30) a = 1;
    if (f3 == 3'd5 && b30) a = 9;
    return a;
  endfunction

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    int   s;
    s = $signed(w);
    e = '{pc: pc, imm: 32'd0, rs1: w[19:15], rs2: w[24:20], rd: w[11:7], alu: 0,
          aluSrc: 1'b0, regWrite: 1'b0, memWrite: 1'b0, branch: 1'b0, jump: 1'b0,
          illegal: 1'b0, resultSrc: 0, funct3: w[14:12]};
    case (w[6:0])
      7'h03: begin e.imm = s >>> 20; e.aluSrc = 1; e.regWrite = 1; e.resultSrc = 1; end
      7'h13: begin e.imm = s >>> 20; e.aluSrc = 1; e.regWrite = 1; e.alu = aluFor(w[14:12], w[30], 1'b0); end
      7'h17: begin e.imm = w & 32'hFFFFF000; e.aluSrc = 1; e.regWrite = 1; end
      7'h23: begin e.imm = ((s >>> 25) << 5) | int'(w[11:7]); e.aluSrc = 1; e.memWrite = 1; end
      7'h33: begin e.regWrite = 1; e.alu = aluFor(w[14:12], w[30], 1'b1); end
      7'h37: begin e.imm = w & 32'hFFFFF000; e.aluSrc = 1; e.regWrite = 1; e.alu = 10; end
      7'h63: begin
        e.imm = ((s >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
        e.branch = 1; e.alu = 1;
      end
      7'h67: begin e.imm = s >>> 20; e.aluSrc = 1; e.regWrite = 1; e.jump = 1; e.resultSrc = 2; end
      7'h6F: begin
        e.imm = ((s >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
        e.aluSrc = 1; e.regWrite = 1; e.jump = 1; e.resultSrc = 2;
      end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two accepted words, oldest at the output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
    end else begin
      mAcc = in_valid && (modelQ.size() < 2);
      mRet = (modelQ.size() > 0) && out_ready;
      if (flush) begin
        modelQ.delete();
      end else begin
        if (mRet) void'(modelQ.pop_front());
        if (mAcc) modelQ.push_back('{pc: in_pc, instr: in_instr});
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("in_ready", in_ready, modelQ.size() < 2);
      checkOutput("out_valid", out_valid, modelQ.size() > 0);
      if (modelQ.size() > 0) begin
        cmpExp = model(modelQ[0].pc, modelQ[0].instr);
        checkOutput("pc", out_pc, cmpExp.pc);
        checkOutput("imm", out_imm, cmpExp.imm);
        checkOutput("rs1", out_rs1, cmpExp.rs1);
        checkOutput("rs2", out_rs2, cmpExp.rs2);
        checkOutput("rd", out_rd, cmpExp.rd);
        checkOutput("alu_ctrl", out_alu_ctrl, cmpExp.alu);
        checkOutput("alu_src", out_alu_src, cmpExp.aluSrc);
        checkOutput("reg_write", out_reg_write, cmpExp.regWrite);
        checkOutput("mem_write", out_mem_write, cmpExp.memWrite);
        checkOutput("result_src", out_result_src, cmpExp.resultSrc);
        checkOutput("branch", out_branch, cmpExp.branch);
        checkOutput("jump", out_jump, cmpExp.jump);
        checkOutput("br_funct3", out_br_funct3, cmpExp.funct3);
        checkOutput("illegal", out_illegal, cmpExp.illegal);
      end
      if (out_valid && out_ready) retiredPcs.push_back(out_pc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] NOP = 32'h00000013;
  logic [31:0] prog [15] = '{32'h00A00093, 32'h40208133, 32'h002081B3, 32'h4030D213,
                             32'h40000293, 32'h0040A303, 32'hFE112E23, 32'h123453B7,
                             32'hFFFFF417, 32'h008004EF, 32'h00008567, 32'h0020C663,
                             32'h4020D5B3, 32'h0020A633, 32'h00000000};
  int   idx, cyc;
  logic rdy;

  initial begin
    in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; flush = 0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_pc", out_pc, 0);
    checkOutput("reset_imm", out_imm, 0);
    checkOutput("reset_illegal", out_illegal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOn = 1'b1;

    // addi x1,x0,5 from EMPTY
    applyStimulus(1, 32'h0, 32'h00500093, 0, 0);
    checkOutput("addi_valid", out_valid, 1);
    checkOutput("addi_rd", out_rd, 1);
    checkOutput("addi_rs1", out_rs1, 0);
    checkOutput("addi_imm", out_imm, 5);
    checkOutput("addi_alu", out_alu_ctrl, 0);
    checkOutput("addi_alu_src", out_alu_src, 1);
    checkOutput("addi_reg_write", out_reg_write, 1);

    // beq x1,x2,-4 accepted while addi retires
    applyStimulus(1, 32'h4, 32'hFE208EE3, 1, 0);
    checkOutput("beq_pc", out_pc, 32'h4);
    checkOutput("beq_imm", out_imm, 32'hFFFFFFFC);
    checkOutput("beq_branch", out_branch, 1);
    checkOutput("beq_funct3", out_br_funct3, 0);
    checkOutput("beq_alu", out_alu_ctrl, 1);
    checkOutput("beq_reg_write", out_reg_write, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("drain_valid", out_valid, 0);

    // all-ones word is illegal
    applyStimulus(1, 32'h8, 32'hFFFFFFFF, 0, 0);
    checkOutput("ill_illegal", out_illegal, 1);
    checkOutput("ill_reg_write", out_reg_write, 0);
    checkOutput("ill_mem_write", out_mem_write, 0);
    checkOutput("ill_branch", out_branch, 0);
    checkOutput("ill_jump", out_jump, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // backpressure for three cycles while streaming 0,4,8,12
    retiredPcs.delete();
    applyStimulus(1, 32'd0, NOP, 0, 0);
    applyStimulus(1, 32'd4, NOP, 0, 0);
    checkOutput("bp_full_ready", in_ready, 0);
    applyStimulus(1, 32'd8, NOP, 0, 0);
    checkOutput("bp_hold_ready", in_ready, 0);
    checkOutput("bp_hold_pc", out_pc, 0);
    applyStimulus(1, 32'd8, NOP, 1, 0);
    checkOutput("bp_release_pc", out_pc, 4);
    applyStimulus(1, 32'd8, NOP, 1, 0);
    applyStimulus(1, 32'd12, NOP, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("bp_count", retiredPcs.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("bp_order", (i < retiredPcs.size()) ? retiredPcs[i] : 32'hDEAD, 4 * i);

    // flush while full, with a word offered in the same cycle
    applyStimulus(1, 32'h40, NOP, 0, 0);
    applyStimulus(1, 32'h44, NOP, 0, 0);
    checkOutput("fl_full_ready", in_ready, 0);
    applyStimulus(1, 32'h48, NOP, 0, 1);
    checkOutput("fl_valid", out_valid, 0);
    checkOutput("fl_ready", in_ready, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fl_not_accepted", out_valid, 0);

    // sustained stream with out_ready held high
    idx = 0;
    cyc = 0;
    while (idx < 15 && cyc < 60) begin
      rdy = in_ready;
      applyStimulus(1, 32'h100 + 32'(4 * idx), prog[idx], 1, 0);
      if (rdy) idx++;
      cyc++;
    end
    checkOutput("stream_cycles", cyc, 15);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);

    // asynchronous reset pulse while one entry is held
    applyStimulus(1, 32'h200, NOP, 0, 0);
    checkOutput("rst_pre_valid", out_valid, 1);
    in_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", out_valid, 0);
    checkOutput("rst_async_ready", in_ready, 1);
    checkOutput("rst_async_pc", out_pc, 0);
    #1 rst_n = 1'b1;
    applyStimulus(1, 32'h300, 32'h00500093, 0, 0);
    checkOutput("rst_after_valid", out_valid, 1);
    checkOutput("rst_after_pc", out_pc, 32'h300);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);

    checkOn = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
